fetch_redirect_unit: RTL
========================

Name: fetch_redirect_unit

Overview:
- Instruction-fetch stage: owns the program counter, drives the synchronous instruction memory, and holds the IF/ID pipeline register.
- Consumes the 3-bit PC_SEL produced by the EX-stage branch control generator plus the three EX-computed targets.
- On a taken redirect it reloads the PC, squashes the wrong-path instruction in IF/ID, and raises FLUSH for the ID/EX register.
- Also enforces instruction-address alignment and runs a post-reset boot delay.

Parameters:
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset.
- TRAP_VECTOR, 32'h0000_0100, PC loaded on a misaligned redirect target.
- BOOT_CYCLES, 4, cycles after reset release before fetching starts (memory init latency); legal range 1..15.

Ports:
- CLK  in  1  single clock, rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- PC_SEL  in  3  from branch control generator: 000 PC+4, 001 JALR, 010 branch taken, 011 JAL, 1xx treated as 000.
- JALR_TARGET  in  32  rs1+imm from EX.
- BRANCH_TARGET  in  32  PC_EX+B-imm.
- JAL_TARGET  in  32  PC_EX+J-imm.
- EX_VALID  in  1  instruction in EX is real, not a bubble.
- STALL  in  1  load-use stall from hazard unit.
- IMEM_DATA  in  32  registered memory output; valid one cycle after an IMEM_RDEN=1 address; held while IMEM_RDEN=0.
- IMEM_ADDR  out  32  = PC (combinational).
- IMEM_RDEN  out  1  memory read enable.
- IFID_PC  out  32  PC of the instruction in IF/ID.
- IFID_INSTR  out  32  IMEM_DATA when IFID_VALID=1, else NOP 32'h0000_0013.
- IFID_VALID  out  1  IF/ID holds a real instruction.
- FLUSH  out  1  squash ID/EX this cycle (combinational).
- MISALIGN  out  1  one-cycle pulse: misaligned target trapped.
- PC  out  32  current fetch PC.
- REDIRECT_CNT  out  32  count of accepted redirects and traps; wraps.

Behaviour:
Reset (async, RST_N=0):
- PC=RESET_VECTOR, IFID_PC=0, IFID_VALID=0, MISALIGN=0, REDIRECT_CNT=0, state=BOOT, boot counter=0.
- Outputs: FLUSH=0, IMEM_RDEN=0.

FSM:
- BOOT: PC held, IMEM_RDEN=0, IFID_VALID stays 0, FLUSH=0; redirect and STALL inputs ignored.
- BOOT -> RUN once the boot counter reaches BOOT_CYCLES-1. Exactly BOOT_CYCLES cycles are spent in BOOT.
- RUN: no exit except reset.

Definitions (RUN only):
- take = EX_VALID and PC_SEL in {001,010,011}.
- tgt = JALR_TARGET with bit0 cleared (001), BRANCH_TARGET (010), or JAL_TARGET (011).
- trap = take and tgt[1]=1.
- redir = take and not trap.

Per-cycle priority in RUN (highest first):
1. trap: PC<=TRAP_VECTOR, IFID_VALID<=0, MISALIGN<=1, REDIRECT_CNT+1, FLUSH=1.
2. redir: PC<=tgt, IFID_VALID<=0, REDIRECT_CNT+1, FLUSH=1.
3. STALL: PC, IFID_PC and IFID_VALID hold; IMEM_RDEN=0, so memory holds IMEM_DATA.
4. else: PC<=PC+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0), IFID_PC<=PC, IFID_VALID<=1.

Other rules:
- IMEM_RDEN = RUN and (not STALL or trap or redir).
- MISALIGN<=0 on every cycle without trap.
- Redirect or trap overrides a simultaneous STALL: the stalled IF/ID instruction is wrong-path and is squashed.
- Redirect penalty: 2 bubbles. IF/ID is cleared, and ID/EX is cleared via FLUSH.
- First valid IF/ID is the cycle after the first RUN fetch, with IFID_PC=RESET_VECTOR.
- PC_SEL=000 with EX_VALID=1 is normal sequential flow.
- Redirect with EX_VALID=0 is ignored (no FLUSH, no count).
- REDIRECT_CNT wraps from 32'hFFFF_FFFF to 0.
- Reset asserted mid-operation returns everything to reset values immediately, regardless of STALL or redirect.

Test Plan:
- Boot: release RST_N with BOOT_CYCLES=4 -> IMEM_RDEN=0 for 4 cycles; then IMEM_ADDR=0,4,8 on successive cycles; IFID_VALID rises one cycle after the first fetch with IFID_PC=0.
- Taken branch: at PC=0x20, drive PC_SEL=010, EX_VALID=1, BRANCH_TARGET=0x80 -> FLUSH=1 that cycle; next cycle PC=0x80 and IFID_VALID=0 (IFID_INSTR=0x00000013); REDIRECT_CNT=1; two bubbles reach EX.
- JALR LSB clear and stall priority: PC_SEL=001, JALR_TARGET=0x41, STALL=1 same cycle -> PC=0x40, IMEM_RDEN=1, FLUSH=1; with STALL=1 alone -> PC, IFID_PC and IFID_INSTR held for 3 stalled cycles.
- Misaligned: PC_SEL=011, JAL_TARGET=0x102 -> PC=0x100 (TRAP_VECTOR), MISALIGN high exactly 1 cycle, FLUSH=1.
- Ignored: PC_SEL=010 with EX_VALID=0, and PC_SEL=110 with EX_VALID=1 -> PC+4, FLUSH=0, count unchanged. Separately, PC=0xFFFFFFFC wraps to 0.
- Reset mid-redirect: assert RST_N=0 asynchronously during a redirect cycle -> PC=RESET_VECTOR and IFID_VALID=0 immediately; BOOT repeats.

Source files
------------

// File: rtl/fetch_redirect_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_redirect_unit
//  Purpose  : Instruction-fetch stage. Owns the program counter, drives the
//             synchronous instruction memory and holds the IF/ID pipeline
//             register. Applies EX-stage redirects (JALR / branch / JAL),
//             squashes wrong-path work, traps misaligned targets and runs a
//             post-reset boot delay before the first fetch.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk            in   1   rising-edge clock
//    rst_n          in   1   asynchronous active-low reset
//    pc_sel         in   3   000 PC+4, 001 JALR, 010 branch, 011 JAL, 1xx = 000
//    jalr_target    in  32   rs1+imm from EX (bit 0 is cleared here)
//    branch_target  in  32   PC_EX + B-imm
//    jal_target     in  32   PC_EX + J-imm
//    ex_valid       in   1   instruction in EX is real (not a bubble)
//    stall          in   1   load-use stall from the hazard unit
//    imem_data      in  32   registered memory read data
//    imem_addr      out 32   fetch address (= pc)
//    imem_rden      out  1   memory read enable
//    ifid_pc        out 32   PC of the instruction held in IF/ID
//    ifid_instr     out 32   instruction in IF/ID, NOP when not valid
//    ifid_valid     out  1   IF/ID holds a real instruction
//    flush          out  1   squash ID/EX this cycle
//    misalign       out  1   one-cycle pulse after a misaligned target trap
//    pc             out 32   current fetch PC
//    redirect_cnt   out 32   accepted redirects + traps (wrapping)
// ============================================================================
module fetch_redirect_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int unsigned BOOT_CYCLES  = 4              // legal range 1..15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  pc_sel,
  input  logic [31:0] jalr_target,
  input  logic [31:0] branch_target,
  input  logic [31:0] jal_target,
  input  logic        ex_valid,
  input  logic        stall,
  input  logic [31:0] imem_data,
  output logic [31:0] imem_addr,
  output logic        imem_rden,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_instr,
  output logic        ifid_valid,
  output logic        flush,
  output logic        misalign,
  output logic [31:0] pc,
  output logic [31:0] redirect_cnt
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [31:0] c_NOP       = 32'h0000_0013;   // addi x0, x0, 0
  localparam logic [3:0]  c_BOOT_LAST = 4'(BOOT_CYCLES - 1);

  localparam logic [2:0]  c_SEL_JALR   = 3'b001;
  localparam logic [2:0]  c_SEL_BRANCH = 3'b010;
  localparam logic [2:0]  c_SEL_JAL    = 3'b011;

  // --------------------------------------------------------------------------
  // State machine encoding
  // --------------------------------------------------------------------------
  typedef enum logic [0:0] {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  // --------------------------------------------------------------------------
  // Registers and their next-state values
  // --------------------------------------------------------------------------
  logic [3:0]  r_boot_cnt;
  logic [3:0]  w_boot_cnt_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] r_ifid_pc;
  logic [31:0] w_ifid_pc_nxt;
  logic        r_ifid_valid;
  logic        w_ifid_valid_nxt;
  logic        r_misalign;
  logic        w_misalign_nxt;
  logic [31:0] r_redirect_cnt;
  logic [31:0] w_redirect_cnt_nxt;

  // Combinational decode of the EX-stage redirect request
  logic        w_run;
  logic        w_take;
  logic [31:0] w_tgt;
  logic        w_trap;
  logic        w_redir;
  logic        w_flush;
  logic        w_rden;

  // --------------------------------------------------------------------------
  // Redirect decode
  // --------------------------------------------------------------------------
  assign w_run = (r_state == ST_RUN);

  // Only the three control-transfer encodings redirect; 000 and all 1xx
  // codes are plain sequential flow. Bubbles in EX never redirect.
  assign w_take = w_run && ex_valid &&
                  ((pc_sel == c_SEL_JALR) ||
                   (pc_sel == c_SEL_BRANCH) ||
                   (pc_sel == c_SEL_JAL));

  // JALR clears bit 0 of its target (RISC-V semantics). Bit 0 of the other
  // targets is never examined, only bit 1 decides misalignment.
  always_comb begin
    w_tgt = 32'h0000_0000;
    case (pc_sel)
      c_SEL_JALR:   w_tgt = jalr_target & 32'hFFFF_FFFE;
      c_SEL_BRANCH: w_tgt = branch_target;
      c_SEL_JAL:    w_tgt = jal_target;
      default:      w_tgt = 32'h0000_0000;
    endcase
  end

  assign w_trap  = w_take &&  w_tgt[1];
  assign w_redir = w_take && !w_tgt[1];

  // --------------------------------------------------------------------------
  // Next-state and output logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt        = r_state;
    w_boot_cnt_nxt     = r_boot_cnt;
    w_pc_nxt           = r_pc;
    w_ifid_pc_nxt      = r_ifid_pc;
    w_ifid_valid_nxt   = r_ifid_valid;
    w_misalign_nxt     = 1'b0;
    w_redirect_cnt_nxt = r_redirect_cnt;
    w_flush            = 1'b0;
    w_rden             = 1'b0;

    case (r_state)
      ST_BOOT: begin
        // Memory is still initialising: nothing is fetched and every
        // redirect/stall request is ignored.
        if (r_boot_cnt == c_BOOT_LAST) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_boot_cnt_nxt = r_boot_cnt + 4'd1;
        end
      end

      ST_RUN: begin
        // A redirect must fetch the new target even while stalled: the
        // stalled IF/ID content is wrong-path and gets squashed anyway.
        w_rden = !stall || w_take;

        if (w_trap) begin
          w_pc_nxt           = TRAP_VECTOR;
          w_ifid_valid_nxt   = 1'b0;
          w_misalign_nxt     = 1'b1;
          w_redirect_cnt_nxt = r_redirect_cnt + 32'd1;
          w_flush            = 1'b1;
        end else if (w_redir) begin
          w_pc_nxt           = w_tgt;
          w_ifid_valid_nxt   = 1'b0;
          w_redirect_cnt_nxt = r_redirect_cnt + 32'd1;
          w_flush            = 1'b1;
        end else if (!stall) begin
          // Sequential fetch; the instruction fetched at r_pc arrives on
          // imem_data next cycle, so IF/ID captures r_pc alongside it.
          w_pc_nxt         = r_pc + 32'd4;
          w_ifid_pc_nxt    = r_pc;
          w_ifid_valid_nxt = 1'b1;
        end
      end

      default: begin
        w_state_nxt = ST_BOOT;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_BOOT;
      r_boot_cnt     <= 4'd0;
      r_pc           <= RESET_VECTOR;
      r_ifid_pc      <= 32'h0000_0000;
      r_ifid_valid   <= 1'b0;
      r_misalign     <= 1'b0;
      r_redirect_cnt <= 32'h0000_0000;
    end else begin
      r_state        <= w_state_nxt;
      r_boot_cnt     <= w_boot_cnt_nxt;
      r_pc           <= w_pc_nxt;
      r_ifid_pc      <= w_ifid_pc_nxt;
      r_ifid_valid   <= w_ifid_valid_nxt;
      r_misalign     <= w_misalign_nxt;
      r_redirect_cnt <= w_redirect_cnt_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign pc           = r_pc;
  assign imem_addr    = r_pc;
  assign imem_rden    = w_rden;
  assign flush        = w_flush;
  assign ifid_pc      = r_ifid_pc;
  assign ifid_valid   = r_ifid_valid;
  // Squashed or not-yet-filled slots present a NOP downstream.
  assign ifid_instr   = r_ifid_valid ? imem_data : c_NOP;
  assign misalign     = r_misalign;
  assign redirect_cnt = r_redirect_cnt;

endmodule
`default_nettype wire
